axis_dp_firewall_fsm: RTL and testbench



---
 rtl/axis_dp_firewall_fsm_pkg.sv | 14 +
 rtl/axis_dp_firewall_fsm_dp_timeout_counter.sv | 35 +++
 rtl/axis_dp_firewall_fsm.sv | 169 ++++++++++++++++
 tb/tb_axis_dp_firewall_fsm.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_dp_firewall_fsm_pkg.sv
// Shared state encoding for the firewall FSM and the downstream output multiplexer,
// so both sides always decode the same select values.
package axis_dp_firewall_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE               = 3'd0,
    ST_PARSE_DATA         = 3'd1,
    ST_CONTROL            = 3'd2,
    ST_SEND_ANALYSED_DATA = 3'd3,
    ST_SEND_REMAIN        = 3'd4,
    ST_DROP               = 3'd5
  } state_e;

endpackage

// File: rtl/axis_dp_firewall_fsm_dp_timeout_counter.sv
// Verdict wait timer: cleared outside CONTROL, counts while enabled, saturates at TIMEOUT-1.
// Expired is registered-state based, so it is valid one cycle per count.
module dp_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expired)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/axis_dp_firewall_fsm.sv
// Packet firewall sequencer: parse header, await verdict, then forward (deparser header + source
// remainder) or drain both streams. One cycle per transition; handshakes combinational from state.
module axis_dp_firewall_fsm
  import axis_dp_firewall_fsm_pkg::*;
#(
  parameter logic [2:0] IDLE               = ST_IDLE,
  parameter logic [2:0] PARSE_DATA         = ST_PARSE_DATA,
  parameter logic [2:0] CONTROL            = ST_CONTROL,
  parameter logic [2:0] SEND_ANALYSED_DATA = ST_SEND_ANALYSED_DATA,
  parameter logic [2:0] SEND_REMAIN        = ST_SEND_REMAIN,
  parameter logic [2:0] DROP               = ST_DROP,
  parameter int         TIMEOUT            = 64,
  parameter int         CNT_WIDTH          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [2:0]           state,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  input  logic                 parse_done,
  input  logic                 verdict_valid,
  input  logic                 verdict_drop,
  output logic                 verdict_ready,
  input  logic                 dp_tvalid,
  input  logic                 dp_tlast,
  output logic                 dp_tready,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [CNT_WIDTH-1:0] pass_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  state_e                 state_q, state_d;
  logic                   short_pkt_q, short_pkt_d;
  logic                   dp_last_q, dp_last_d;
  logic [CNT_WIDTH-1:0]   pass_count_q, pass_count_d;
  logic [CNT_WIDTH-1:0]   drop_count_q, drop_count_d;
  logic                   tmr_expired;
  logic                   src_last_seen, dp_last_seen;
  logic                   s_rdy, v_rdy, d_rdy, m_vld, m_lst;
  logic [2:0]             state_enc;

  dp_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != ST_CONTROL),
    .en      (state_q == ST_CONTROL),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    short_pkt_d   = short_pkt_q;
    dp_last_d     = dp_last_q;
    pass_count_d  = pass_count_q;
    drop_count_d  = drop_count_q;
    src_last_seen = 1'b0;
    dp_last_seen  = 1'b0;
    s_rdy = 1'b0;
    v_rdy = 1'b0;
    d_rdy = 1'b0;
    m_vld = 1'b0;
    m_lst = 1'b0;
    case (state_q)
      ST_IDLE: begin
        short_pkt_d = 1'b0;
        dp_last_d   = 1'b0;
        if (s_axis_tvalid)
          state_d = ST_PARSE_DATA;
      end
      ST_PARSE_DATA: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid && s_axis_tlast)
          short_pkt_d = 1'b1;
        if (parse_done)
          state_d = ST_CONTROL;
      end
      ST_CONTROL: begin
        v_rdy = 1'b1;
        if (verdict_valid) begin
          if (verdict_drop) begin
            state_d      = ST_DROP;
            drop_count_d = drop_count_q + CNT_WIDTH'(1);
          end else begin
            state_d = ST_SEND_ANALYSED_DATA;
          end
        end else if (tmr_expired) begin
          state_d      = ST_DROP;
          drop_count_d = drop_count_q + CNT_WIDTH'(1);
        end
      end
      ST_SEND_ANALYSED_DATA: begin
        m_vld = dp_tvalid;
        d_rdy = m_axis_tready;
        m_lst = dp_tlast & short_pkt_q;
        if (dp_tvalid && m_axis_tready && dp_tlast) begin
          if (short_pkt_q) begin
            state_d      = ST_IDLE;
            pass_count_d = pass_count_q + CNT_WIDTH'(1);
          end else begin
            state_d = ST_SEND_REMAIN;
          end
        end
      end
      ST_SEND_REMAIN: begin
        m_vld = s_axis_tvalid;
        s_rdy = m_axis_tready;
        m_lst = s_axis_tlast;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          state_d      = ST_IDLE;
          pass_count_d = pass_count_q + CNT_WIDTH'(1);
        end
      end
      ST_DROP: begin
        // Drain both streams; leave only once each has delivered its last beat.
        s_rdy         = 1'b1;
        d_rdy         = 1'b1;
        src_last_seen = short_pkt_q | (s_axis_tvalid & s_axis_tlast);
        dp_last_seen  = dp_last_q | (dp_tvalid & dp_tlast);
        short_pkt_d   = src_last_seen;
        dp_last_d     = dp_last_seen;
        if (src_last_seen && dp_last_seen)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      short_pkt_q  <= 1'b0;
      dp_last_q    <= 1'b0;
      pass_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      short_pkt_q  <= short_pkt_d;
      dp_last_q    <= dp_last_d;
      pass_count_q <= pass_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_IDLE:               state_enc = IDLE;
      ST_PARSE_DATA:         state_enc = PARSE_DATA;
      ST_CONTROL:            state_enc = CONTROL;
      ST_SEND_ANALYSED_DATA: state_enc = SEND_ANALYSED_DATA;
      ST_SEND_REMAIN:        state_enc = SEND_REMAIN;
      ST_DROP:               state_enc = DROP;
      default:               state_enc = IDLE;
    endcase
  end

  // Reset forces the visible state and all handshakes quiet within the reset cycle itself.
  assign state         = rst ? IDLE : state_enc;
  assign s_axis_tready = s_rdy & ~rst;
  assign verdict_ready = v_rdy & ~rst;
  assign dp_tready     = d_rdy & ~rst;
  assign m_axis_tvalid = m_vld & ~rst;
  assign m_axis_tlast  = m_lst & ~rst;
  assign pass_count    = rst ? '0 : pass_count_q;
  assign drop_count    = rst ? '0 : drop_count_q;

endmodule

// File: tb/tb_axis_dp_firewall_fsm.sv
// Directed bench for axis_dp_firewall_fsm: output beats are scored against an expected-token queue.
module tb_axis_dp_firewall_fsm;

  logic        clk, rst;
  logic [2:0]  state;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic        parse_done, verdict_valid, verdict_drop, verdict_ready;
  logic        dp_tvalid, dp_tlast, dp_tready;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [31:0] pass_count, drop_count;

  axis_dp_firewall_fsm #(.TIMEOUT(8), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .state(state),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .parse_done(parse_done), .verdict_valid(verdict_valid), .verdict_drop(verdict_drop),
    .verdict_ready(verdict_ready),
    .dp_tvalid(dp_tvalid), .dp_tlast(dp_tlast), .dp_tready(dp_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .pass_count(pass_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int src_idx, src_len, dp_idx, dp_len;
  bit src_en, dp_en;
  int mrdy_mode;
  int mv_cnt;
  logic [7:0] sb[$];
  logic [2:0] slog[$];
  logic [2:0] last_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tok(input bit src, input bit last, input int idx);
    logic [5:0] i6;
    i6 = 6'(idx);
    return {src, last, i6};
  endfunction

  task automatic drive();
    s_axis_tvalid = src_en && (src_idx < src_len);
    s_axis_tlast  = (src_idx == src_len - 1);
    dp_tvalid     = dp_en && (dp_idx < dp_len);
    dp_tlast      = (dp_idx == dp_len - 1);
    case (mrdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'b0;
    endcase
  endtask

  // One clock: score any output transfer, advance the bench's stream models, log state changes.
  task automatic cyc();
    logic s_f, d_f, stall;
    logic [7:0] obs;
    #1;
    s_f = s_axis_tvalid && s_axis_tready;
    d_f = dp_tvalid && dp_tready;
    if (m_axis_tvalid) mv_cnt++;
    if (m_axis_tvalid && m_axis_tready) begin
      obs = tok(s_axis_tready, m_axis_tlast, s_axis_tready ? src_idx : dp_idx);
      if (sb.size() == 0) chk("unexpected_beat", {24'd0, obs}, 32'hFFFF_FFFF);
      else chk("out_beat", {24'd0, obs}, {24'd0, sb.pop_front()});
    end
    stall = (state == 3'd4) && s_axis_tvalid && !m_axis_tready;
    @(posedge clk);
    #1;
    if (s_f) src_idx++;
    if (d_f) dp_idx++;
    if (state != last_state) begin
      slog.push_back(state);
      last_state = state;
    end
    if (stall) chk("remain_hold", {29'd0, state}, 32'd4);
    drive();
  endtask

  task automatic start_pkt(input int len);
    src_idx = 0; src_len = len; src_en = 1'b1;
    dp_idx = 0; dp_len = 2; dp_en = 1'b1;
    slog.delete();
    slog.push_back(state);
    last_state = state;
    mv_cnt = 0;
    drive();
  endtask

  task automatic parse_at(input int k);
    int n = 0;
    while (src_idx < k && n < 50) begin cyc(); n++; end
    chk("parse_reach", src_idx, k);
    parse_done = 1'b1;
    cyc();
    parse_done = 1'b0;
  endtask

  task automatic verdict(input int wait_cyc, input bit drop);
    repeat (wait_cyc) cyc();
    verdict_valid = 1'b1;
    verdict_drop  = drop;
    cyc();
    verdict_valid = 1'b0;
    verdict_drop  = 1'b0;
  endtask

  task automatic wait_st(input logic [2:0] s, input int lim);
    int n = 0;
    while (state !== s && n < lim) begin cyc(); n++; end
    chk("wait_state", {29'd0, state}, {29'd0, s});
  endtask

  task automatic chk_log(input string tag, input int len, input logic [31:0] packed_exp);
    logic [31:0] p = 0;
    foreach (slog[i]) p = (p << 3) | 32'(slog[i]);
    chk({tag, "_len"}, slog.size(), len);
    chk(tag, p, packed_exp);
  endtask

  initial begin
    int n;
    rst = 1'b1; parse_done = 0; verdict_valid = 0; verdict_drop = 0;
    src_en = 0; dp_en = 0; src_idx = 0; src_len = 0; dp_idx = 0; dp_len = 2;
    mrdy_mode = 0; mv_cnt = 0; m_axis_tready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    s_axis_tvalid = 1; dp_tvalid = 1; verdict_valid = 1;
    #1;
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_rdy", {28'd0, s_axis_tready, verdict_ready, dp_tready, m_axis_tvalid}, 0);
    chk("rst_pass", pass_count, 0);
    chk("rst_drop", drop_count, 0);
    rst = 1'b0;
    s_axis_tvalid = 0; dp_tvalid = 0;
    #1;
    chk("idle_verdict_ignored", {31'd0, verdict_ready}, 0);
    verdict_valid = 0;
    @(posedge clk); #1;
    chk("idle_hold", {29'd0, state}, 0);

    // 5-beat pass: header after beat 4, verdict on 2nd CONTROL cycle
    start_pkt(5);
    sb.push_back(tok(0, 0, 0)); sb.push_back(tok(0, 0, 1)); sb.push_back(tok(1, 1, 4));
    parse_at(3);
    verdict(1, 0);
    wait_st(3'd0, 30);
    chk_log("pass_states", 6, 32'o012340);
    chk("pass_cnt1", pass_count, 1);
    chk("pass_src_all", src_idx, 5);
    chk("pass_sb_empty", sb.size(), 0);

    // Same packet, dropped by verdict
    start_pkt(5);
    parse_at(3);
    verdict(1, 1);
    wait_st(3'd0, 30);
    chk_log("drop_states", 5, 32'o01250);
    chk("drop_cnt1", drop_count, 1);
    chk("drop_src_all", src_idx, 5);
    chk("drop_dp_all", dp_idx, 2);
    chk("drop_no_mvalid", mv_cnt, 0);

    // Timeout with no verdict: DROP exactly TIMEOUT cycles after CONTROL entry
    start_pkt(5);
    parse_at(3);
    chk("to_in_control", {29'd0, state}, 2);
    n = 0;
    while (state !== 3'd5 && n < 40) begin cyc(); n++; end
    chk("to_cycles", n, 8);
    wait_st(3'd0, 30);
    chk("to_drop_cnt", drop_count, 2);
    chk("to_pass_cnt", pass_count, 1);

    // Short packet: tlast coincides with parse_done
    start_pkt(3);
    sb.push_back(tok(0, 0, 0)); sb.push_back(tok(0, 1, 1));
    parse_at(2);
    verdict(0, 0);
    wait_st(3'd0, 30);
    chk_log("short_states", 5, 32'o01230);
    chk("short_pass_cnt", pass_count, 2);
    chk("short_sb_empty", sb.size(), 0);

    // Downstream ready toggling during the remainder
    mrdy_mode = 1;
    start_pkt(6);
    sb.push_back(tok(0, 0, 0)); sb.push_back(tok(0, 0, 1));
    for (int i = 2; i < 6; i++) sb.push_back(tok(1, i == 5, i));
    parse_at(1);
    verdict(0, 0);
    wait_st(3'd0, 60);
    chk_log("toggle_states", 6, 32'o012340);
    chk("toggle_pass_cnt", pass_count, 3);
    chk("toggle_sb_empty", sb.size(), 0);
    chk("toggle_src_all", src_idx, 6);
    mrdy_mode = 0;

    // Reset mid-packet in SEND_REMAIN, then residual beats form a fresh packet
    start_pkt(5);
    sb.push_back(tok(0, 0, 0)); sb.push_back(tok(0, 0, 1)); sb.push_back(tok(1, 0, 2));
    parse_at(1);
    verdict(0, 0);
    n = 0;
    while (src_idx < 3 && n < 30) begin cyc(); n++; end
    chk("rr_in_remain", {29'd0, state}, 4);
    mrdy_mode = 2; m_axis_tready = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    #1;
    chk("rr_rdy_during", {28'd0, s_axis_tready, verdict_ready, dp_tready, m_axis_tvalid}, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rr_state", {29'd0, state}, 0);
    chk("rr_pass", pass_count, 0);
    chk("rr_drop", drop_count, 0);
    chk("rr_rdy_after", {28'd0, s_axis_tready, verdict_ready, dp_tready, m_axis_tvalid}, 0);
    chk("rr_src_kept", src_idx, 3);
    mrdy_mode = 0; dp_idx = 0;
    slog.delete(); slog.push_back(state); last_state = state;
    drive();
    sb.push_back(tok(0, 0, 0)); sb.push_back(tok(0, 1, 1));
    parse_at(4);
    verdict(0, 0);
    wait_st(3'd0, 30);
    chk_log("rr_states", 5, 32'o01230);
    chk("rr_pass_new", pass_count, 1);
    chk("rr_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
